// File: rtl/lif_neuron_array.sv
// Array of integrate-and-fire neurons with a shared runtime threshold, reset mode and refractory period.
// Optional leak term is compiled in when LIF_LEAK_EN is defined.
module lif_neuron_array #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int REFRAC    = 2,
  parameter int THR_RESET = 230
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_en,
  input  logic [N_NEURONS*WIDTH-1:0] current,
  input  logic                       cfg_we,
  input  logic [WIDTH-1:0]           cfg_thr,
  input  logic                       cfg_mode,
  input  logic [2:0]                 cfg_leak,
  output logic [N_NEURONS-1:0]       spike,
  output logic                       spike_any,
  output logic [N_NEURONS*WIDTH-1:0] state
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [WIDTH-1:0]     thr_reg;
  logic                 mode_reg;
  logic [N_NEURONS-1:0] spike_next;
  logic [N_NEURONS-1:0] spike_reg;
  logic                 spike_any_reg;

`ifdef LIF_LEAK_EN
  logic [2:0] leak_reg;
`else
  logic unused_leak;
  assign unused_leak = ^cfg_leak;
`endif

  // Config registered at the edge; a step in the same cycle still sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_reg  <= WIDTH'(THR_RESET);
      mode_reg <= 1'b0;
`ifdef LIF_LEAK_EN
      leak_reg <= 3'd0;
`endif
    end else if (cfg_we) begin
      thr_reg  <= cfg_thr;
      mode_reg <= cfg_mode;
`ifdef LIF_LEAK_EN
      leak_reg <= cfg_leak;
`endif
    end
  end

  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_ch
    logic [WIDTH-1:0] u_reg, u_next;
    logic [RW-1:0]    ref_reg, ref_next;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] cur;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH-1:0] sum_sat;
    logic             fire;

    assign cur = current[gi*WIDTH +: WIDTH];

`ifdef LIF_LEAK_EN
    // Shift of zero removes the whole potential, i.e. full leak.
    assign leaked = u_reg - (u_reg >> leak_reg);
`else
    assign leaked = u_reg;
`endif

    assign sum_wide = {1'b0, leaked} + {1'b0, cur};
    assign sum_sat  = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];

    always_comb begin
      u_next   = u_reg;
      ref_next = ref_reg;
      fire     = 1'b0;
      if (step_en) begin
        if (ref_reg != '0) begin
          ref_next = ref_reg - RW'(1);
        end else if (sum_sat >= thr_reg) begin
          fire     = 1'b1;
          ref_next = RW'(REFRAC);
          u_next   = mode_reg ? (sum_sat - thr_reg) : '0;
        end else begin
          u_next = sum_sat;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        u_reg   <= '0;
        ref_reg <= '0;
      end else begin
        u_reg   <= u_next;
        ref_reg <= ref_next;
      end
    end

    assign spike_next[gi]             = fire;
    assign state[gi*WIDTH +: WIDTH] = u_reg;
  end

  // fire is already zero when step_en is low, so spikes clear on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_reg     <= '0;
      spike_any_reg <= 1'b0;
    end else begin
      spike_reg     <= spike_next;
      spike_any_reg <= |spike_next;
    end
  end

  assign spike     = spike_reg;
  assign spike_any = spike_any_reg;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed vector tables, hand sequences and a random run
// against an arithmetic reference model (honours LIF_LEAK_EN like the design).
module tb_lif_neuron_array;

  localparam int N      = 4;
  localparam int W      = 8;
  localparam int REFRAC = 2;
  localparam int THR0   = 230;

  logic          clk;
  logic          rst_n;
  logic          step_en;
  logic [N*W-1:0] current;
  logic          cfg_we;
  logic [W-1:0]  cfg_thr;
  logic          cfg_mode;
  logic [2:0]    cfg_leak;
  logic [N-1:0]  spike;
  logic          spike_any;
  logic [N*W-1:0] state;

  lif_neuron_array #(
    .N_NEURONS(N), .WIDTH(W), .REFRAC(REFRAC), .THR_RESET(THR0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .current(current),
    .cfg_we(cfg_we), .cfg_thr(cfg_thr), .cfg_mode(cfg_mode), .cfg_leak(cfg_leak),
    .spike(spike), .spike_any(spike_any), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integers per channel
  int mu[N];
  int mref[N];
  int mthr, mmode, mleak;
  logic [N-1:0] m_spike;
  logic         m_any;

  typedef struct {
    bit          pre_rst;
    bit          step;
    logic [31:0] cur;
    bit          we;
    logic [7:0]  thr;
    bit          mode;
    logic [31:0] exp_state;
    logic [3:0]  exp_spike;
    bit          exp_any;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit pre_rst, bit step, logic [31:0] cur, bit we, logic [7:0] thr,
                              bit mode, logic [31:0] es, logic [3:0] sp, bit any);
    vec_t v;
    v.pre_rst = pre_rst; v.step = step; v.cur = cur; v.we = we; v.thr = thr; v.mode = mode;
    v.exp_state = es; v.exp_spike = sp; v.exp_any = any;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mu[i] = 0;
      mref[i] = 0;
    end
    mthr = THR0; mmode = 0; mleak = 0;
    m_spike = '0; m_any = 1'b0;
  endtask

  task automatic model_apply(input bit step, input logic [31:0] cur, input bit we,
                             input int thr, input int mode, input int leak);
    int l, s, c;
    m_spike = '0;
    if (step) begin
      for (int i = 0; i < N; i++) begin
        c = int'(cur[i*W +: W]);
        if (mref[i] > 0) begin
          mref[i]--;
        end else begin
`ifdef LIF_LEAK_EN
          l = (mleak == 0) ? 0 : mu[i] - mu[i] / (1 << mleak);
`else
          l = mu[i];
`endif
          s = l + c;
          if (s > 255) s = 255;
          if (s >= mthr) begin
            m_spike[i] = 1'b1;
            mref[i] = REFRAC;
            mu[i] = (mmode != 0) ? s - mthr : 0;
          end else begin
            mu[i] = s;
          end
        end
      end
    end
    m_any = |m_spike;
    if (we) begin
      mthr = thr; mmode = mode; mleak = leak;
    end
  endtask

  function automatic logic [31:0] m_state();
    logic [31:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = 8'(mu[i]);
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model, and land 1 ns after the edge.
  task automatic apply(input bit step, input logic [31:0] cur, input bit we,
                       input logic [7:0] thr, input bit mode, input logic [2:0] leak);
    step_en = step; current = cur; cfg_we = we; cfg_thr = thr; cfg_mode = mode; cfg_leak = leak;
    model_apply(step, cur, we, int'(thr), int'(mode), int'(leak));
    @(posedge clk);
    #1;
    $display("txn step=%0b cur=%08h we=%0b thr=%0d mode=%0b -> state=%08h spike=%b any=%b",
             step, cur, we, thr, mode, state, spike, spike_any);
  endtask

  task automatic do_reset();
    step_en = 1'b0; cfg_we = 1'b0; current = '0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      if (tbl[k].pre_rst) do_reset();
      apply(tbl[k].step, tbl[k].cur, tbl[k].we, tbl[k].thr, tbl[k].mode, 3'd0);
      check($sformatf("vec%0d_state", k), 64'(state), 64'(tbl[k].exp_state));
      check($sformatf("vec%0d_spike", k), 64'(spike), 64'(tbl[k].exp_spike));
      check($sformatf("vec%0d_any", k), 64'(spike_any), 64'(tbl[k].exp_any));
    end
  endtask

  int a_end, b_end, c_end, d_end;
  int leak_exp[4];

  initial begin
    // Zero-reset with refractory on ch0, current 100
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h64, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'hC8, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h00, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h64, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'hC8, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h64, 0, 0, 0, 32'h00, 4'b0001, 1));
    a_end = tbl.size();
    // Subtract mode, thr=100, ch1 current 60 (ch0 still refractory for two steps)
    tbl.push_back(mk(0, 0, 32'h0,    1, 100, 1, 32'h0,    4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h3C00, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h1400, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h1400, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h1400, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h5000, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h3C00, 0, 0,   0, 32'h2800, 4'b0010, 1));
    b_end = tbl.size();
    // Config/step collision on ch2, then gating
    tbl.push_back(mk(1, 1, 32'h280000, 0, 0,  0, 32'h280000, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h140000, 1, 50, 0, 32'h3C0000, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 32'h140000, 0, 0,  0, 32'h3C0000, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h0,      0, 0,  0, 32'h0,      4'b0100, 1));
    tbl.push_back(mk(0, 0, 32'h0,      0, 0,  0, 32'h0,      4'b0000, 0));
    c_end = tbl.size();
    // Parallel firing at saturation; thr=0 in subtract mode keeps U=sum
    tbl.push_back(mk(1, 1, 32'hFFFFFFFF, 0, 0, 0, 32'h0, 4'b1111, 1));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'h0, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 32'h05,       0, 0, 0, 32'h05, 4'b1111, 1));
    d_end = tbl.size();

    rst_n = 1'b0; step_en = 1'b0; current = '0; cfg_we = 1'b0;
    cfg_thr = '0; cfg_mode = 1'b0; cfg_leak = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state", 64'(state), 64'h0);
    check("reset_spike", 64'(spike), 64'h0);
    check("reset_any", 64'(spike_any), 64'h0);

    run_range(0, a_end);

    // Async reset mid-cycle while spike is high
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", 64'(state), 64'h0);
    check("async_rst_spike", 64'(spike), 64'h0);
    check("async_rst_any", 64'(spike_any), 64'h0);
    #1 rst_n = 1'b1;
    model_reset();
    apply(1'b1, 32'd231, 1'b0, 8'd0, 1'b0, 3'd0);
    check("thr_default_spike", 64'(spike), 64'h1);
    check("thr_default_state", 64'(state), 64'h0);

    run_range(a_end, d_end);

    // Leak on ch3
    do_reset();
`ifdef LIF_LEAK_EN
    leak_exp = '{100, 50, 25, 13};
`else
    leak_exp = '{200, 200, 200, 200};
`endif
    apply(1'b0, 32'h0, 1'b1, 8'd230, 1'b0, 3'd1);
    apply(1'b1, 32'hC8000000, 1'b0, 8'd0, 1'b0, 3'd0);
    check("leak_load", 64'(state), 64'hC8000000);
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 32'h0, 1'b0, 8'd0, 1'b0, 3'd0);
      check($sformatf("leak_step%0d", k), 64'(state[31:24]), 64'(leak_exp[k]));
    end

    // Random run against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [31:0] cur;
      bit st, we, md;
      logic [7:0] th;
      logic [2:0] lk;
      for (int i = 0; i < N; i++)
        cur[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                    : 8'($urandom_range(0, 80));
      st = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 15) == 0);
      th = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      md = 1'($urandom_range(0, 1));
      lk = 3'($urandom_range(0, 7));
      apply(st, cur, we, th, md, lk);
      check($sformatf("rnd%0d_state", k), 64'(state), 64'(m_state()));
      check($sformatf("rnd%0d_spike", k), 64'(spike), 64'(m_spike));
      check($sformatf("rnd%0d_any", k), 64'(spike_any), 64'(m_any));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
- N_NEURONS independent integrate-and-fire neurons sharing one runtime-configurable threshold, reset mode and leak.
- Generalises the single 8-bit, fixed-threshold, zero-reset neuron. Adds width and channel parameters, subtract/zero reset selection, a refractory period, saturating integration, gated time steps and optional leak.
- Sits between the input-current driver (per-channel synaptic sums) and the spike consumer.

Parameters:
N_NEURONS, 4, number of neuron channels
WIDTH, 8, membrane potential / current / threshold width (unsigned)
REFRAC, 2, refractory steps after a spike (0 = none); counter width clog2(REFRAC+1), min 1
THR_RESET, 230, threshold value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
step_en  in  1  advance all neurons one time step this cycle
current  in  N_NEURONS*WIDTH  input current, channel i at [i*WIDTH +: WIDTH]
cfg_we  in  1  write configuration this cycle
cfg_thr  in  WIDTH  new threshold
cfg_mode  in  1  new reset mode: 0 = reset to zero, 1 = subtract threshold
cfg_leak  in  3  new leak shift (used only with LIF_LEAK_EN)
spike  out  N_NEURONS  registered spike, one bit per channel
spike_any  out  1  registered OR of the next-cycle spike vector (coincident with spike)
state  out  N_NEURONS*WIDTH  membrane potentials U_i (registered)

Behaviour:
- Reset (async, rst_n=0): U_i=0, refractory counters=0, spike=0, spike_any=0, thr=THR_RESET, mode=0, leak=0. Reset is effective immediately mid-operation; the first step is processed on the first rising edge after release.
- Config: when cfg_we=1, thr/mode/leak are registered at the edge. A step in the same cycle uses the OLD config. New config applies from the next cycle.
- step_en=0: U_i and refractory counters hold; spike and spike_any clear to 0 at the edge.
- step_en=1, per channel i, evaluated in parallel at the edge:
  - If ref_i != 0: ref_i decrements, U_i holds, current_i is ignored, spike_i=0.
  - Else: L = U_i - (U_i >> leak) with LIF_LEAK_EN, else L = U_i. sum = L + current_i, computed at WIDTH+1 bits and saturated to 2^WIDTH-1.
    - If sum >= thr: spike_i=1, ref_i=REFRAC. U_i becomes 0 when mode=0, or sum-thr when mode=1.
    - Else: U_i=sum, spike_i=0.
- thr=0: every non-refractory step spikes. Mode 1 then leaves U_i=sum.
- Latency: current sampled at edge k appears in state/spike after edge k (one cycle). spike is a one-cycle pulse per firing step.
- Saturation: U_i never wraps. Sum at max with thr <= max always fires.
- Channels are fully independent. Only config is shared.

Optional Feature:
- LIF_LEAK_EN defined: leak term active. cfg_leak=0 means full leak (L=0). Values 1..7 remove U>>leak per non-refractory step.
- LIF_LEAK_EN undefined: no leak logic; cfg_leak is ignored and L=U_i (pure IF).

Test Plan:
- Reset and config defaults:
  - Stimulus: assert rst_n=0 mid-run, asynchronously between edges.
  - Response: spike=0, spike_any=0 and all state=0 immediately. A subsequent step with current 231 on ch0 (mode 0, REFRAC=2) spikes, proving thr=230.
- Zero reset with refractory (defaults, REFRAC=2):
  - Stimulus: ch0 current 100, step_en=1 continuously.
  - Response: U0 = 100, 200; then sum saturates at 255, spike0=1 and U0=0. Two held steps follow (U0=0, spike0=0), then 100. Channels 1-3 stay 0.
- Subtract mode:
  - Stimulus: cfg thr=100, mode=1; then ch1 current 60.
  - Response: U1 = 60; then 120, spike1=1 and U1=20. Hold, hold; then 80; then 140, spike1=1 and U1=40. spike_any pulses with each spike.
- Config/step collision and gating:
  - Stimulus: in one cycle, cfg_we with thr=50 while step_en=1, U2=40, current2=20.
  - Response: the old thr=230 applies, so U2=60 and no spike. With step_en=0 next cycle, U2 holds at 60 and spike clears.
- Leak (LIF_LEAK_EN):
  - Stimulus: leak=1, U3 driven to 200, then current 0.
  - Response: U3 = 100, 50, 25, 13. Without the macro, U3 holds at 200.
- Parallel firing:
  - Stimulus: all four channels at current 255 on the same step.
  - Response: spike=4'b1111 and spike_any=1 in the same cycle.
